pe_sched: RTL and testbench
===========================

# pe_sched

Sequencer for the 4-PE SSD block-matching chain. It fetches a 4x4 reference block and a 7-pixel-wide search strip from synchronous-read buffers, streams them into the first PE with a qualifying enable, and collects the 4 PEs' SSD results. It tracks the minimum SSD and its (dx, dy) motion vector. It sits between the frame-buffer/line-buffer logic and the PE chain and is started once per reference block.

## Interface
- `V_RANGE`, default 4: number of vertical search offsets (dy = 0..V_RANGE-1), range 1..16.
- `AW`, default 3: search-buffer address width; must satisfy 2^AW ≥ V_RANGE+3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to process a block; ignored while busy.
- `busy` out 1: high in ISSUE and DRAIN.
- `done` out 1: one-cycle pulse when the result is final.
- `err` out 1: drain watchdog fired; valid with done (only if macro enabled, else tied 0).
- `ref_addr` out 2: reference row address (0..3).
- `ref_rdata` in 32: 4 reference pixels of the addressed row, {p3,p2,p1,p0}, 1-cycle read latency.
- `srh_addr` out AW: search row address.
- `srh_rdata` in 56: 7 search pixels {s6..s0}, 1-cycle read latency.
- `pe_en` out 1: enable to PE0.
- `pe_ref` out 32: equals `ref_rdata`, combinational.
- `pe_srh` out 56: equals `srh_rdata`, combinational.
- `ssd_vld` in 4: per-PE SSD valid, bit k = PE k (dx = k).
- `ssd_data` in 80: per-PE 20-bit SSD, PE k at [20k+19:20k].
- `best_ssd` out 20: minimum SSD found.
- `best_dx` out 2, `best_dy` out 4: position of the minimum.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `start` → ISSUE. On this transition: clear the issue counter i, clear per-PE result counters, set `best_ssd`=20'hFFFFF, `best_dx`=0, `best_dy`=0, `err`=0.
  - ISSUE: each cycle drive `ref_addr`=i mod 4 and `srh_addr`=(i div 4)+(i mod 4), then increment i. After issue i=4·V_RANGE-1 → DRAIN.
  - DRAIN: stay until the total results counted = 4·V_RANGE, then → DONE.
  - DONE: `done`=1 for exactly one cycle → IDLE.
- `pe_en` = issue-valid delayed 1 cycle, aligned to read data.
- Result collection is active in ISSUE and DRAIN. For each set bit k of `ssd_vld`:
  - dy = per-PE counter k, then the counter increments.
  - The candidate (ssd, dx=k, dy) replaces the best if ssd < best_ssd, or if ssd == best_ssd and {dy,dx} < {best_dy,best_dx}. The outcome is independent of arrival order.
  - Up to 4 simultaneous valids are merged in one cycle.
- `ssd_vld` in IDLE/DONE is ignored and not counted. A per-PE count beyond V_RANGE is ignored.
- `start` in any state other than IDLE is ignored.
- `rst` at any time: next state IDLE. All outputs at reset values: `busy`=0, `done`=0, `err`=0, `pe_en`=0, `ref_addr`=0, `srh_addr`=0, `best_ssd`=20'hFFFFF, `best_dx`=0, `best_dy`=0.
- `best_*` are held from `done` until the next accepted `start`.

## Timing
- `start` sampled at cycle T → ISSUE at T+1. Addresses are valid T+1..T+4·V_RANGE; `pe_en` is high T+2..T+4·V_RANGE+1, continuous with no bubbles.
- `busy` rises at T+1.
- `done` is asserted the cycle after the last result is accepted; `busy` is low in that cycle.
- Minimum start-to-start spacing: one idle cycle after `done`.

## Configuration
- `PE_SCHED_WDOG_EN` defined:
  - In DRAIN, a 6-bit counter resets on any `ssd_vld` and increments otherwise.
  - On reaching 63 the FSM goes to DONE with `err`=1. `best_*` reflects the results received so far.
- Undefined: no counter; DRAIN waits indefinitely; `err` is constant 0.

## Test plan
- Reset: hold `rst` 2 cycles mid-ISSUE. Required: IDLE next cycle, `pe_en`=0, `best_ssd`=20'hFFFFF, `busy`=0, and no `done`.
- Address sequence, V_RANGE=4: `ref_addr` = 0,1,2,3 repeating. `srh_addr` = 0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6. `pe_en` high exactly 16 cycles starting T+2.
- Unique minimum: model returns SSD 500 everywhere except PE2 dy=3 → 17. Required: `best_ssd`=17, `best_dx`=2, `best_dy`=3, single `done` pulse.
- Tie-break: PE3 dy0 and PE1 dy1 both 40, PE1's result arriving first. Required: `best_dx`=3, `best_dy`=0.
- Simultaneous valids: `ssd_vld`=4'b1111 with SSDs 9, 7, 7, 8 in one cycle. Required: best = 7 at dx=1. A `start` during busy has no effect.
- Watchdog (macro on): supply only 15 of 16 results. Required: `done` with `err`=1 exactly 63 idle cycles after the last `ssd_vld`. With the macro off, `busy` stays high.

Source files
------------

// File: rtl/pe_sched.sv
// pe_sched: sequencer for a 4-PE SSD block-matching chain.
// Fetches a 4x4 reference block and a 7-pixel-wide search strip from
// synchronous-read buffers, streams them into PE0, collects the per-PE SSD
// results and keeps the minimum SSD with its (dx, dy) motion vector.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle block request (ignored while busy)
//   busy, done, err     status; done is a one-cycle pulse, err = watchdog fired
//   ref_addr/ref_rdata  reference row buffer (1-cycle read latency)
//   srh_addr/srh_rdata  search row buffer (1-cycle read latency)
//   pe_en/pe_ref/pe_srh stream into PE0, pe_en aligned to the read data
//   ssd_vld/ssd_data    per-PE SSD results, PE k at bit k / [20k+19:20k]
//   best_ssd/dx/dy      running minimum and its position
//
// Optional feature: define PE_SCHED_WDOG_EN to enable the drain watchdog.
// Without it DRAIN waits indefinitely and err is constant 0.
module pe_sched #(
  parameter int unsigned V_RANGE = 4,
  parameter int unsigned AW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    ref_addr,
  input  logic [31:0]   ref_rdata,
  output logic [AW-1:0] srh_addr,
  input  logic [55:0]   srh_rdata,
  output logic          pe_en,
  output logic [31:0]   pe_ref,
  output logic [55:0]   pe_srh,
  input  logic [3:0]    ssd_vld,
  input  logic [79:0]   ssd_data,
  output logic [19:0]   best_ssd,
  output logic [1:0]    best_dx,
  output logic [3:0]    best_dy
);

  localparam int unsigned N_PE  = 4;
  localparam int unsigned SW    = 20;
  localparam int unsigned N_RES = N_PE * V_RANGE;
  localparam int unsigned IW    = 6;   // issue index 0..63
  localparam int unsigned CW    = 5;   // per-PE result count 0..16
  localparam int unsigned TW    = 7;   // total result count 0..64

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [CW-1:0]   cnt_q [N_PE];
  logic [CW-1:0]   cnt_d [N_PE];
  logic [SW-1:0]   best_ssd_q, best_ssd_d;
  logic [1:0]      best_dx_q, best_dx_d;
  logic [3:0]      best_dy_q, best_dy_d;
  logic [1:0]      ref_addr_q, ref_addr_d;
  logic [AW-1:0]   srh_addr_q, srh_addr_d;
  logic            pe_en_q, pe_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SW-1:0]   cand_ssd;
  logic [3:0]      cand_dy;
  logic [1:0]      cand_dx;
  logic [TW-1:0]   total_d;

`ifdef PE_SCHED_WDOG_EN
  localparam int unsigned WW = 6;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            err_q, err_d;
`endif

  // Next-state, address generation and result merge
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    cnt_d      = cnt_q;
    best_ssd_d = best_ssd_q;
    best_dx_d  = best_dx_q;
    best_dy_d  = best_dy_q;
    ref_addr_d = ref_addr_q;
    srh_addr_d = srh_addr_q;
    cand_ssd   = '0;
    cand_dy    = '0;
    cand_dx    = '0;
    total_d    = '0;
`ifdef PE_SCHED_WDOG_EN
    wdog_d     = wdog_q;
    err_d      = err_q;
`endif

    // Lexicographic (ssd, dy, dx) key is a total order, so merging several
    // simultaneous results in any sequence gives the same winner.
    if (state_q == S_ISSUE || state_q == S_DRAIN) begin
      for (int k = 0; k < N_PE; k++) begin
        if (ssd_vld[k] && (cnt_q[k] < CW'(V_RANGE))) begin
          cand_ssd = ssd_data[SW*k +: SW];
          cand_dy  = cnt_q[k][3:0];
          cand_dx  = 2'(k);
          if ((cand_ssd < best_ssd_d) ||
              ((cand_ssd == best_ssd_d) &&
               ({cand_dy, cand_dx} < {best_dy_d, best_dx_d}))) begin
            best_ssd_d = cand_ssd;
            best_dx_d  = cand_dx;
            best_dy_d  = cand_dy;
          end
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end

    for (int k = 0; k < N_PE; k++) begin
      total_d = total_d + TW'(cnt_d[k]);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          i_d        = '0;
          cnt_d      = '{default: '0};
          best_ssd_d = '1;
          best_dx_d  = '0;
          best_dy_d  = '0;
          ref_addr_d = '0;
          srh_addr_d = '0;
`ifdef PE_SCHED_WDOG_EN
          err_d      = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
`ifdef PE_SCHED_WDOG_EN
        wdog_d = '0;
`endif
        if (i_q == IW'(N_RES - 1)) begin
          state_d = S_DRAIN;
        end else begin
          // Address for the next issue: row i mod 4 of the 4x4 block,
          // search row (i div 4) + (i mod 4)
          i_d        = i_q + IW'(1);
          ref_addr_d = i_d[1:0];
          srh_addr_d = AW'(i_d[IW-1:2]) + AW'(i_d[1:0]);
        end
      end
      S_DRAIN: begin
        if (total_d == TW'(N_RES)) begin
          state_d = S_DONE;
        end
`ifdef PE_SCHED_WDOG_EN
        else begin
          wdog_d = (|ssd_vld) ? '0 : (wdog_q + WW'(1));
          if (wdog_d == '1) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pe_en_d = (state_q == S_ISSUE);
    busy_d  = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      cnt_q      <= '{default: '0};
      best_ssd_q <= '1;
      best_dx_q  <= '0;
      best_dy_q  <= '0;
      ref_addr_q <= '0;
      srh_addr_q <= '0;
      pe_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      cnt_q      <= cnt_d;
      best_ssd_q <= best_ssd_d;
      best_dx_q  <= best_dx_d;
      best_dy_q  <= best_dy_d;
      ref_addr_q <= ref_addr_d;
      srh_addr_q <= srh_addr_d;
      pe_en_q    <= pe_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef PE_SCHED_WDOG_EN
  // Drain watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign ref_addr = ref_addr_q;
  assign srh_addr = srh_addr_q;
  assign pe_en    = pe_en_q;
  assign pe_ref   = ref_rdata;
  assign pe_srh   = srh_rdata;
  assign best_ssd = best_ssd_q;
  assign best_dx  = best_dx_q;
  assign best_dy  = best_dy_q;

endmodule

// File: tb/tb_pe_sched.sv
// tb_pe_sched: randomized self-checking bench for pe_sched (V_RANGE=4, AW=3).
// Result arrivals are scheduled per cycle; a list-based reference model
// derives the expected minimum, its position and the done cycle.
module tb_pe_sched;

  localparam int V    = 4;
  localparam int AW   = 3;
  localparam int NR   = 4 * V;
  localparam int MAXC = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic [1:0]    ref_addr;
  logic [31:0]   ref_rdata;
  logic [AW-1:0] srh_addr;
  logic [55:0]   srh_rdata;
  logic          pe_en;
  logic [31:0]   pe_ref;
  logic [55:0]   pe_srh;
  logic [3:0]    ssd_vld;
  logic [79:0]   ssd_data;
  logic [19:0]   best_ssd;
  logic [1:0]    best_dx;
  logic [3:0]    best_dy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [4];
  logic [55:0] srh_mem [2**AW];

  logic [3:0]  sv [MAXC];
  logic [19:0] sd [MAXC][4];

  pe_sched #(.V_RANGE(V), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ref_addr  (ref_addr),
    .ref_rdata (ref_rdata),
    .srh_addr  (srh_addr),
    .srh_rdata (srh_rdata),
    .pe_en     (pe_en),
    .pe_ref    (pe_ref),
    .pe_srh    (pe_srh),
    .ssd_vld   (ssd_vld),
    .ssd_data  (ssd_data),
    .best_ssd  (best_ssd),
    .best_dx   (best_dx),
    .best_dy   (best_dy)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffers
  always @(posedge clk) begin
    ref_rdata <= ref_mem[ref_addr];
    srh_rdata <= srh_mem[srh_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      sv[c] = '0;
      for (int k = 0; k < 4; k++) sd[c][k] = '0;
    end
  endtask

  task automatic add_res(input int c, input int k, input logic [19:0] s);
    sv[c][k] = 1'b1;
    sd[c][k] = s;
  endtask

  // Per PE: V arrivals 1..3 cycles apart; PE3 starts late so the last one
  // lands in the drain phase.
  task automatic gen_random(output int last3);
    int c;
    logic [19:0] s;
    last3 = 0;
    for (int k = 0; k < 4; k++) begin
      c = (k == 3) ? NR - 1 : int'($urandom_range(2, NR));
      for (int j = 0; j < V; j++) begin
        s = ($urandom_range(0, 3) != 0) ? 20'($urandom_range(0, 31)) : 20'($urandom);
        add_res(c, k, s);
        if (k == 3) last3 = c;
        c += int'($urandom_range(1, 3));
      end
    end
  endtask

  // Reference: the j-th counted result of PE k is (dx=k, dy=j); best is the
  // smallest by (ssd, dy, dx); done one cycle after the last counted result.
  task automatic model(output logic [19:0] bs, output logic [1:0] bx, output logic [3:0] by,
                       output int dc, output logic e_err, output int last_any);
    int cnt [4];
    int tot;
    int dy;
    bs = 20'hFFFFF; bx = '0; by = '0; dc = 0; e_err = 1'b0; last_any = 0; tot = 0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 1; c < MAXC && dc == 0; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (sv[c][k]) begin
          last_any = c;
          if (cnt[k] < V) begin
            dy = cnt[k];
            cnt[k]++;
            tot++;
            if ((sd[c][k] < bs) ||
                ((sd[c][k] == bs) && ((dy * 4 + k) < (int'(by) * 4 + int'(bx))))) begin
              bs = sd[c][k];
              bx = 2'(k);
              by = 4'(dy);
            end
            if (tot == NR) dc = c + 1;
          end
        end
      end
    end
`ifdef PE_SCHED_WDOG_EN
    if (dc == 0) begin
      dc    = last_any + 64;
      e_err = 1'b1;
    end
`endif
  endtask

  // Runs one block from the current negedge; stray_c is a cycle where a
  // (to be ignored) start is pulsed while busy. Returns at an idle negedge.
  task automatic run_block(input string name, input int stray_c);
    logic [19:0] e_ssd;
    logic [1:0]  e_dx;
    logic [3:0]  e_dy;
    logic        e_err;
    int          dc, last_any, stop_c, j;
    for (int r = 0; r < 4; r++) ref_mem[r] = $urandom;
    for (int r = 0; r < 2**AW; r++) srh_mem[r] = 56'({$urandom, $urandom});
    model(e_ssd, e_dx, e_dy, dc, e_err, last_any);
    stop_c = (dc != 0) ? dc : last_any + 100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= stop_c; c++) begin
      if (c <= NR) begin
        chk({name, "_ref_addr"}, 64'(ref_addr), 64'((c - 1) % 4));
        chk({name, "_srh_addr"}, 64'(srh_addr), 64'((c - 1) / 4 + (c - 1) % 4));
      end
      chk({name, "_pe_en"}, 64'(pe_en), 64'(c >= 2 && c <= NR + 1));
      if (c >= 2 && c <= NR + 1) begin
        j = c - 2;
        chk({name, "_pe_ref"}, 64'(pe_ref), 64'(ref_mem[j % 4]));
        chk({name, "_pe_srh"}, 64'(pe_srh), 64'(srh_mem[j / 4 + j % 4]));
      end
      if (c == dc) begin
        chk({name, "_done"}, 64'(done), 64'(1));
        chk({name, "_busy_at_done"}, 64'(busy), 64'(0));
        chk({name, "_err"}, 64'(err), 64'(e_err));
        chk({name, "_best_ssd"}, 64'(best_ssd), 64'(e_ssd));
        chk({name, "_best_dx"}, 64'(best_dx), 64'(e_dx));
        chk({name, "_best_dy"}, 64'(best_dy), 64'(e_dy));
      end else begin
        chk({name, "_done_low"}, 64'(done), 64'(0));
        chk({name, "_busy_high"}, 64'(busy), 64'(1));
      end
      start   = (c == stray_c);
      ssd_vld = sv[c];
      for (int k = 0; k < 4; k++) ssd_data[20*k +: 20] = sd[c][k];
      if (c == dc) begin
        // results offered in DONE must be ignored
        ssd_vld  = 4'hF;
        ssd_data = '0;
        start    = 1'b0;
      end
      @(negedge clk);
    end
    ssd_vld  = '0;
    ssd_data = '0;
    start    = 1'b0;
    if (dc != 0) begin
      chk({name, "_done_pulse"}, 64'(done), 64'(0));
      chk({name, "_idle_busy"}, 64'(busy), 64'(0));
      chk({name, "_held_ssd"}, 64'(best_ssd), 64'(e_ssd));
      chk({name, "_held_pos"}, 64'({best_dy, best_dx}), 64'({e_dy, e_dx}));
    end
  endtask

  initial begin
    int last3;
    rst = 1'b1; start = 1'b0; ssd_vld = '0; ssd_data = '0;
    for (int r = 0; r < 4; r++) ref_mem[r] = '0;
    for (int r = 0; r < 2**AW; r++) srh_mem[r] = '0;
    clear_sched();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_pe_en", 64'(pe_en), 64'(0));
    chk("rst_addr", 64'({ref_addr, srh_addr}), 64'(0));
    chk("rst_best_ssd", 64'(best_ssd), 64'(20'hFFFFF));
    chk("rst_best_pos", 64'({best_dy, best_dx}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reset held for 2 cycles in the middle of ISSUE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_pe_en", 64'(pe_en), 64'(0));
    chk("mid_rst_best", 64'(best_ssd), 64'(20'hFFFFF));
    chk("mid_rst_addr", 64'({ref_addr, srh_addr}), 64'(0));
    for (int c = 0; c < 30; c++) begin
      chk("mid_rst_quiet", 64'({busy, done, pe_en}), 64'(0));
      @(negedge clk);
    end

    // Unique minimum at PE2 dy3
    clear_sched();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < V; j++) add_res(6 + 3 * j + k, k, 20'd500);
    add_res(6 + 3 * 3 + 2, 2, 20'd17);
    run_block("uniq", 0);
    chk("uniq_const", 64'({best_ssd, best_dy, best_dx}), 64'({20'd17, 4'd3, 2'd2}));

    // Tie: PE1 dy1 (arrives first) vs PE3 dy0, both 40
    clear_sched();
    for (int j = 0; j < V; j++) begin
      add_res(7 + 2 * j, 0, 20'd100);
      add_res(6 + 2 * j, 1, 20'd100);
      add_res(9 + 2 * j, 2, 20'd100);
      add_res(14 + j, 3, 20'd100);
    end
    add_res(8, 1, 20'd40);
    add_res(14, 3, 20'd40);
    run_block("tie", 0);
    chk("tie_const", 64'({best_ssd, best_dy, best_dx}), 64'({20'd40, 4'd0, 2'd3}));

    // Four simultaneous valids 9,7,7,8, plus a start while busy
    clear_sched();
    add_res(5, 0, 20'd9);
    add_res(5, 1, 20'd7);
    add_res(5, 2, 20'd7);
    add_res(5, 3, 20'd8);
    for (int k = 0; k < 4; k++)
      for (int j = 1; j < V; j++) add_res(10 + 3 * j + k, k, 20'd100);
    run_block("simul", 3);
    chk("simul_const", 64'({best_ssd, best_dy, best_dx}), 64'({20'd7, 4'd0, 2'd1}));

    // Fifth result from PE0 must be ignored
    clear_sched();
    for (int j = 0; j < V; j++) add_res(3 + j, 0, 20'd100);
    add_res(8, 0, 20'd0);
    for (int k = 1; k < 4; k++)
      for (int j = 0; j < V; j++) add_res(6 + 3 * j + k, k, 20'd200);
    run_block("ovf", 0);
    chk("ovf_const", 64'({best_ssd, best_dy, best_dx}), 64'({20'd100, 4'd0, 2'd0}));

    // Randomized blocks
    for (int t = 0; t < 20; t++) begin
      clear_sched();
      gen_random(last3);
      run_block("rand", int'($urandom_range(2, 2 * NR)));
    end

    // One result missing: watchdog fires, or busy holds without it
    clear_sched();
    gen_random(last3);
    sv[last3][3] = 1'b0;
    run_block("wdog", 0);
`ifndef PE_SCHED_WDOG_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wdog_off_rst_busy", 64'(busy), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
